// File: rtl/circle_job_scheduler_if.sv
// Bundle of requester, generator and consumer signals around the circle job scheduler.
// The slave modport is the scheduler's view; master is the surrounding system.
interface circle_job_scheduler_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic                    req0_valid, req1_valid;
  logic                    req0_accept, req1_accept;
  logic signed [WIDTH-1:0] req0_centre_x, req0_centre_y, req0_radius;
  logic signed [WIDTH-1:0] req1_centre_x, req1_centre_y, req1_radius;
  logic                    abort;
  logic                    gen_start, gen_reset, gen_ready;
  logic                    gen_valid, gen_done;
  logic signed [WIDTH-1:0] gen_centre_x, gen_centre_y, gen_radius;
  logic signed [WIDTH-1:0] gen_out0, gen_out1;
  logic                    _ready, _valid, _owner, job_done;
  logic signed [WIDTH-1:0] _out0, _out1;
  logic        [CNT_W-1:0] job_beats;

  modport slave (
    input  req0_valid, req1_valid,
    input  req0_centre_x, req0_centre_y, req0_radius,
    input  req1_centre_x, req1_centre_y, req1_radius,
    input  abort, gen_valid, gen_done, gen_out0, gen_out1, _ready,
    output req0_accept, req1_accept,
    output gen_start, gen_reset, gen_ready,
    output gen_centre_x, gen_centre_y, gen_radius,
    output _valid, _out0, _out1, _owner, job_done, job_beats
  );

  modport master (
    output req0_valid, req1_valid,
    output req0_centre_x, req0_centre_y, req0_radius,
    output req1_centre_x, req1_centre_y, req1_radius,
    output abort, gen_valid, gen_done, gen_out0, gen_out1, _ready,
    input  req0_accept, req1_accept,
    input  gen_start, gen_reset, gen_ready,
    input  gen_centre_x, gen_centre_y, gen_radius,
    input  _valid, _out0, _out1, _owner, job_done, job_beats
  );
endinterface

// File: rtl/circle_job_scheduler.sv
// Round-robin arbiter between two circle-job requesters sharing one generator;
// forwards generator beats downstream and reports a beat count per finished job.
module circle_job_scheduler #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                  _clock,
  input  logic                  _reset,
  circle_job_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, RUN, FIN} state_t;
  typedef struct packed {
    logic signed [WIDTH-1:0] cx;
    logic signed [WIDTH-1:0] cy;
    logic signed [WIDTH-1:0] r;
  } job_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  job_t             job_q, job_in;
  logic             last_grant, owner_q;
  logic             grant_any, grant_sel;
  logic             xfer, fin;
  logic [CNT_W-1:0] cnt_q, cnt_nxt, beats_q;
  logic             acc0, acc1, start, greset, gready, ovalid, done;

  // Only one valid requester wins outright; with both valid the one not served last wins.
  assign grant_any = bus.req0_valid | bus.req1_valid;
  assign grant_sel = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
  assign job_in    = grant_sel ? '{bus.req1_centre_x, bus.req1_centre_y, bus.req1_radius}
                               : '{bus.req0_centre_x, bus.req0_centre_y, bus.req0_radius};

  assign xfer    = (state == RUN) & ~bus.abort & bus.gen_valid & bus._ready;
  assign fin     = (state == RUN) & ~bus.abort & bus.gen_done  & bus._ready;
  assign cnt_nxt = (xfer && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;

  always_comb begin
    state_nxt = state;
    acc0      = 1'b0;
    acc1      = 1'b0;
    start     = 1'b0;
    greset    = _reset;
    gready    = 1'b0;
    ovalid    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (grant_any) begin
        acc0      = ~grant_sel;
        acc1      = grant_sel;
        state_nxt = START;
      end
      START: if (bus.abort) begin
        greset    = 1'b1;
        state_nxt = IDLE;
      end else begin
        start     = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        gready = bus._ready;
        if (bus.abort) begin
          greset    = 1'b1;
          state_nxt = IDLE;
        end else begin
          ovalid = bus.gen_valid;
          if (fin) state_nxt = FIN;
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Keep every strobe quiet while reset is held, whatever state is still registered.
    if (_reset) begin
      acc0   = 1'b0;
      acc1   = 1'b0;
      start  = 1'b0;
      gready = 1'b0;
      ovalid = 1'b0;
      done   = 1'b0;
    end
  end

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner_q    <= 1'b0;
      job_q      <= '0;
      cnt_q      <= '0;
      beats_q    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_any) begin
        last_grant <= grant_sel;
        owner_q    <= grant_sel;
        job_q      <= job_in;
      end
      cnt_q <= (state == START) ? '0 : cnt_nxt;
      // Final beat of the job may land in the same cycle as done, so latch the post-increment count.
      if (fin) beats_q <= cnt_nxt;
    end
  end

  assign bus.req0_accept  = acc0;
  assign bus.req1_accept  = acc1;
  assign bus.gen_start    = start;
  assign bus.gen_reset    = greset;
  assign bus.gen_ready    = gready;
  assign bus.gen_centre_x = job_q.cx;
  assign bus.gen_centre_y = job_q.cy;
  assign bus.gen_radius   = job_q.r;
  assign bus._valid       = ovalid;
  assign bus._out0        = bus.gen_out0;
  assign bus._out1        = bus.gen_out1;
  assign bus._owner       = owner_q;
  assign bus.job_done     = done;
  assign bus.job_beats    = beats_q;
endmodule

// File: tb/tb_circle_job_scheduler.sv
// Random requesters, a behavioural generator and a scoreboard monitor around the scheduler;
// small CNT_W so the beat counter saturates within a few beats.
module tb_circle_job_scheduler;
  localparam int WIDTH = 32;
  localparam int CNT_W = 3;
  localparam int SAT   = (1 << CNT_W) - 1;

  typedef struct {
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;
    logic                    owner;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  circle_job_scheduler_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus();
  circle_job_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    ._clock(clk),
    ._reset(rst),
    .bus   (bus)
  );

  // requester / consumer stimulus
  logic                    rv [2];
  logic signed [WIDTH-1:0] rx [2], ry [2], rr [2];
  logic                    rdy, ab;
  assign bus.req0_valid    = rv[0];
  assign bus.req0_centre_x = rx[0];
  assign bus.req0_centre_y = ry[0];
  assign bus.req0_radius   = rr[0];
  assign bus.req1_valid    = rv[1];
  assign bus.req1_centre_x = rx[1];
  assign bus.req1_centre_y = ry[1];
  assign bus.req1_radius   = rr[1];
  assign bus._ready        = rdy;
  assign bus.abort         = ab;

  // reference model state: phase of the current job (0 idle, 1 start, 2 run, 3 finish)
  int                      st = 0, run_age = 0, jobs = 0;
  logic                    last_win = 1'b1, exp_owner = 1'b0, rst_prev = 1'b0;
  logic signed [WIDTH-1:0] exp_cx, exp_cy, exp_r;
  beat_t                   exp_q [$];
  logic                    s_acc [2];
  logic                    s_gstart = 1'b0, s_greset = 1'b0, s_gready = 1'b0;

  // generator model
  logic g_active = 1'b0;
  int   g_rem = 0, g_issued = 0;

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: samples on the falling edge and advances the model.
  initial begin
    s_acc[0] = 1'b0;
    s_acc[1] = 1'b0;
    forever begin
      logic v0, v1, w, eab;
      beat_t b;
      @(negedge clk);
      s_acc[0] = bus.req0_accept;
      s_acc[1] = bus.req1_accept;
      s_gstart = bus.gen_start;
      s_greset = bus.gen_reset;
      s_gready = bus.gen_ready;
      if (rst) begin
        chk("rst_accept0", bus.req0_accept, 0);
        chk("rst_accept1", bus.req1_accept, 0);
        chk("rst_gen_start", bus.gen_start, 0);
        chk("rst_valid", bus._valid, 0);
        chk("rst_gen_ready", bus.gen_ready, 0);
        chk("rst_job_done", bus.job_done, 0);
        chk("rst_gen_reset", bus.gen_reset, 1);
        st = 0;
        last_win = 1'b1;
        exp_q.delete();
        rst_prev = 1'b1;
      end else begin
        if (rst_prev) begin
          chk("post_rst_job_beats", bus.job_beats, 0);
          chk("post_rst_owner", bus._owner, 0);
          chk("post_rst_centre_x", bus.gen_centre_x, 0);
          chk("post_rst_radius", bus.gen_radius, 0);
          rst_prev = 1'b0;
        end
        v0  = bus.req0_valid;
        v1  = bus.req1_valid;
        eab = ab && (st == 1 || st == 2);
        w   = (v0 && v1) ? ~last_win : v1;
        chk("gen_reset", bus.gen_reset, eab);
        chk("accept0", bus.req0_accept, st == 0 && (v0 || v1) && !w);
        chk("accept1", bus.req1_accept, st == 0 && (v0 || v1) && w);
        chk("gen_start", bus.gen_start, st == 1 && !ab);
        if (st == 1 && !ab) begin
          chk("gen_centre_x", bus.gen_centre_x, exp_cx);
          chk("gen_centre_y", bus.gen_centre_y, exp_cy);
          chk("gen_radius", bus.gen_radius, exp_r);
        end
        chk("gen_ready", bus.gen_ready, st == 2 ? rdy : 1'b0);
        chk("out_valid", bus._valid, (st == 2 && !ab) ? bus.gen_valid : 1'b0);
        if (bus._valid && rdy) begin
          if (exp_q.size() == 0) chk("beat_expected", 0, 1);
          else begin
            b = exp_q.pop_front();
            chk("beat_out0", bus._out0, b.x);
            chk("beat_out1", bus._out1, b.y);
            chk("beat_owner", bus._owner, b.owner);
          end
        end
        chk("job_done", bus.job_done, st == 3);
        if (st == 3) begin
          jobs++;
          chk("job_beats", bus.job_beats, (g_issued > SAT) ? SAT : g_issued);
          chk("beats_drained", exp_q.size(), 0);
        end
        if (st != 0) chk("owner", bus._owner, exp_owner);
        case (st)
          0: if (v0 || v1) begin
            st        = 1;
            last_win  = w;
            exp_owner = w;
            exp_cx    = rx[w];
            exp_cy    = ry[w];
            exp_r     = rr[w];
          end
          1: begin
            st      = ab ? 0 : 2;
            run_age = 1;
          end
          2: if (ab) st = 0;
             else if (bus.gen_done && rdy) st = 3;
             else run_age++;
          default: st = 0;
        endcase
      end
    end
  end

  // Generator: random beat count and gaps, done either with the last beat or after it.
  initial begin
    bus.gen_valid = 1'b0;
    bus.gen_done  = 1'b0;
    bus.gen_out0  = '0;
    bus.gen_out1  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (s_greset) begin
        g_active      = 1'b0;
        bus.gen_valid = 1'b0;
        bus.gen_done  = 1'b0;
        exp_q.delete();
      end else if (s_gstart) begin
        g_active      = 1'b1;
        g_rem         = $urandom_range(0, 10);
        g_issued      = 0;
        bus.gen_valid = 1'b0;
        bus.gen_done  = 1'b0;
      end else if (g_active) begin
        if (bus.gen_valid && s_gready) bus.gen_valid = 1'b0;
        if (bus.gen_done && s_gready) begin
          g_active      = 1'b0;
          bus.gen_done  = 1'b0;
          bus.gen_valid = 1'b0;
        end else begin
          if (!bus.gen_valid && g_rem > 0 && $urandom_range(0, 3) != 0) begin
            bus.gen_valid = 1'b1;
            bus.gen_out0  = $urandom;
            bus.gen_out1  = $urandom;
            g_rem--;
            g_issued++;
            exp_q.push_back('{bus.gen_out0, bus.gen_out1, exp_owner});
          end
          if (g_rem == 0 && !bus.gen_done && (!bus.gen_valid || $urandom_range(0, 1) == 1))
            bus.gen_done = 1'b1;
        end
      end
    end
  end

  // Stimulus phases: 0 steady ready, 1 both requesting, 2 ready toggling, 3 aborts, 4 mid-job reset.
  initial begin
    for (int n = 0; n < 2; n++) begin
      rv[n] = 1'b0;
      rx[n] = '0;
      ry[n] = '0;
      rr[n] = '0;
    end
    rdy = 1'b0;
    ab  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int ph = 0; ph < 5; ph++) begin
      for (int c = 0; c < 300; c++) begin
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 2; n++) begin
          if (rv[n] && s_acc[n]) rv[n] = 1'b0;
          if (!rv[n] && (ph == 1 || (ph == 3 && n == 1) || $urandom_range(0, 2) == 0)) begin
            rv[n] = 1'b1;
            rx[n] = $urandom;
            ry[n] = $urandom;
            rr[n] = $urandom_range(1, 100);
          end
        end
        case (ph)
          0, 4:    rdy = 1'b1;
          1:       rdy = 1'($urandom_range(0, 1));
          2:       rdy = ~rdy;
          default: rdy = ($urandom_range(0, 3) != 0);
        endcase
        ab = (ph == 3) && ((st == 2 && run_age == 3) ||
                           ((st == 0 || st == 3) && $urandom_range(0, 3) == 0));
        if (ph == 4 && st == 2 && run_age == 2) rst = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    rv[0] = 1'b0;
    rv[1] = 1'b0;
    ab    = 1'b0;
    rdy   = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("jobs_completed", jobs > 30, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/circle_job_scheduler.md
CIRCLE_JOB_SCHEDULER -- requirements
Module: circle_job_scheduler

Interface
REQ-001 Parameter WIDTH, 32, signed width of every coordinate and argument bus.
REQ-002 Parameter CNT_W, 16, width of the per-job beat counter.
REQ-003 _clock  in  1  single clock; all state updates on rising edge.
REQ-004 _reset  in  1  synchronous, active-high reset.
REQ-005 reqN_valid  in  1  (N=0,1) requester N presents a job.
REQ-006 reqN_centre_x, reqN_centre_y, reqN_radius  in  WIDTH each  job arguments for requester N.
REQ-007 reqN_accept  out  1  job of requester N taken this cycle.
REQ-008 abort  in  1  cancel the running job.
REQ-009 gen_start  out  1  one-cycle start pulse to the shared generator.
REQ-010 gen_reset  out  1  reset to the generator: _reset OR abort pulse.
REQ-011 gen_centre_x, gen_centre_y, gen_radius  out  WIDTH each  latched job arguments.
REQ-012 gen_ready  out  1  consumer-ready forwarded to the generator.
REQ-013 gen_valid, gen_done  in  1 each  generator output beat valid / generator finished.
REQ-014 gen_out0, gen_out1  in  WIDTH each  generator output coordinates.
REQ-015 _ready  in  1  downstream consumer ready.
REQ-016 _valid  out  1  output beat valid.
REQ-017 _out0, _out1  out  WIDTH each  forwarded coordinates.
REQ-018 _owner  out  1  requester index of the current job.
REQ-019 job_done  out  1  one-cycle pulse at job completion; job_beats  out  CNT_W  beats forwarded for that job.

Function
REQ-020 FSM states SHALL be IDLE, START, RUN, FIN.
REQ-021 IDLE: if any reqN_valid, grant round-robin starting after last_grant; assert grantee's reqN_accept for one cycle, latch its arguments, set _owner and last_grant, go START.
REQ-022 Both requests valid in IDLE: the requester not equal to last_grant SHALL win; last_grant resets to 1 so requester 0 wins first.
REQ-023 reqN_accept SHALL be asserted only in IDLE and never for two requesters in the same cycle.
REQ-024 START: gen_start=1 for exactly one cycle with latched arguments stable on gen_centre_x/y/radius; beat counter cleared; go RUN.
REQ-025 gen_centre_x/y/radius SHALL hold latched values from START until the next accept.
REQ-026 RUN: gen_ready=_ready, _valid=gen_valid, _out0/_out1=gen_out0/gen_out1, combinationally; outside RUN gen_ready=0 and _valid=0.
REQ-027 A beat transfers when gen_valid and _ready in RUN; each transfer increments the beat counter, saturating at 2^CNT_W-1.
REQ-028 gen_done and _ready in RUN ends the job; a valid beat in that same cycle SHALL be forwarded and counted; go FIN.
REQ-029 gen_done with _ready=0 SHALL NOT end the job; RUN holds.
REQ-030 FIN: job_done=1 for one cycle, job_beats=final count; go IDLE; job_beats holds until the next FIN.
REQ-031 abort in START or RUN: gen_reset=1 that cycle, _valid=0, no job_done, go IDLE next cycle; last_grant keeps the aborted owner.
REQ-032 abort in IDLE or FIN SHALL be ignored (FIN still pulses job_done).
REQ-033 Requests arriving outside IDLE SHALL wait; requesters hold reqN_valid and arguments until accepted.

Reset
REQ-034 On _reset: state IDLE, last_grant=1, counter 0, job_beats 0, _owner 0, latched arguments 0; all 1-bit outputs 0 except gen_reset=1.
REQ-035 _reset mid-job SHALL drop the job without job_done; first accept is possible the cycle after _reset deasserts.

Verification
REQ-036 Req0 job (50,50,8), _ready=1 -> accept0 at cycle 1, gen_start at cycle 2, every beat forwarded with _owner=0, job_done with job_beats equal to generator beat count.
REQ-037 req0 and req1 both valid continuously -> grants alternate 0,1,0,1; no double accept.
REQ-038 _ready toggling 1/0 each cycle in RUN -> gen_ready mirrors it, no beat lost or duplicated, count unchanged versus _ready=1 run.
REQ-039 gen_done with gen_valid same cycle, _ready=1 -> final beat forwarded, counted, FIN next cycle.
REQ-040 abort 3 cycles into RUN with req1 pending -> gen_reset pulse, no job_done, accept1 one cycle later.
REQ-041 _reset asserted in RUN -> all outputs at reset values next cycle; new req0 accepted the cycle after release.
